// File: rtl/sos_chain_ctrl.sv
// sos_chain_ctrl: sequencer and double-buffered coefficient store for a biquad cascade.
// On each sample_trig the sections fire in order, each advancing on its stage_done.
// A hung stage aborts the sample (timeout_err). A sample_trig that arrives mid-chain is
// dropped (overrun). Coefficient commits are deferred until the chain is idle.
// Optional feature macro: SOS_CTRL_BYPASS_EN (per-stage bypass mask, stage_bypass_o port).
module sos_chain_ctrl #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned CW     = 16,
    parameter int unsigned TMO    = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 sample_trig_i,
    output logic [STAGES-1:0]    stage_trig_o,
    input  logic [STAGES-1:0]    stage_done_i,
    input  logic                 cfg_we_i,
    input  logic [2:0]           cfg_stage_i,
    input  logic [2:0]           cfg_sel_i,
    input  logic [CW-1:0]        cfg_data_i,
    input  logic                 cfg_commit_i,
    input  logic                 cfg_clr_i,
    output logic [STAGES*CW-1:0] coef_b0_o,
    output logic [STAGES*CW-1:0] coef_b1_o,
    output logic [STAGES*CW-1:0] coef_b2_o,
    output logic [STAGES*CW-1:0] coef_a1_o,
    output logic [STAGES*CW-1:0] coef_a2_o,
    output logic [STAGES*CW-1:0] coef_gain_o,
`ifdef SOS_CTRL_BYPASS_EN
    output logic [STAGES-1:0]    stage_bypass_o,
`endif
    output logic                 busy_o,
    output logic                 sample_valid_o,
    output logic                 commit_pend_o,
    output logic                 overrun_o,
    output logic                 timeout_err_o
);

    localparam int unsigned IW  = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int unsigned TCW = $clog2(TMO);
    localparam int unsigned NC  = 6;  // b0, b1, b2, a1, a2, gain
    localparam logic [CW-1:0] B0_RST   = CW'(1) << (CW - 2);
    localparam logic [CW-1:0] GAIN_RST = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     idx_q;
    logic [TCW-1:0]    tmo_cnt_q;
    logic [STAGES-1:0] stage_trig_q;
    logic              busy_q;
    logic              sample_valid_q;
    logic              commit_pend_q;
    logic              overrun_q;
    logic              timeout_err_q;
    logic [CW-1:0]     shadow_q [STAGES][NC];
    logic [CW-1:0]     active_q [STAGES][NC];
`ifdef SOS_CTRL_BYPASS_EN
    logic [STAGES-1:0] byp_shadow_q;
    logic [STAGES-1:0] byp_active_q;
`endif

    logic              chain_busy_c;
    logic              idle_copy_c;
    logic [STAGES-1:0] start_mask_c;
    logic [STAGES-1:0] run_mask_c;
    logic              first_hit_c;
    logic [IW-1:0]     first_idx_c;
    logic              next_hit_c;
    logic [IW-1:0]     next_idx_c;
    logic              cur_done_c;
    logic              last_done_c;
    logic              tmo_hit_c;
    logic              ret_idle_c;
    logic              copy_c;

    // Stage selection (skipping bypassed stages), chain end, timeout and commit decisions
    always_comb begin
        chain_busy_c = (state_q != S_IDLE);
        idle_copy_c  = !chain_busy_c && cfg_commit_i;
`ifdef SOS_CTRL_BYPASS_EN
        run_mask_c   = byp_active_q;
        start_mask_c = idle_copy_c ? byp_shadow_q : byp_active_q;
`else
        run_mask_c   = '0;
        start_mask_c = '0;
`endif
        first_hit_c = 1'b0;
        first_idx_c = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (!start_mask_c[i]) begin
                first_hit_c = 1'b1;
                first_idx_c = IW'(i);
            end
        end
        next_hit_c = 1'b0;
        next_idx_c = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (i > int'(idx_q) && !run_mask_c[i]) begin
                next_hit_c = 1'b1;
                next_idx_c = IW'(i);
            end
        end
        cur_done_c  = stage_done_i[idx_q];
        last_done_c = chain_busy_c && cur_done_c && !next_hit_c;
        tmo_hit_c   = chain_busy_c && !cur_done_c && (tmo_cnt_q == TCW'(TMO - 1));
        ret_idle_c  = last_done_c || tmo_hit_c;
        copy_c      = idle_copy_c || (ret_idle_c && (commit_pend_q || cfg_commit_i));
    end

    // Sequencer FSM, coefficient store, sticky flags
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            tmo_cnt_q      <= '0;
            stage_trig_q   <= '0;
            busy_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            commit_pend_q  <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                for (int k = 0; k < NC; k++) begin
                    shadow_q[s][k] <= (k == 0) ? B0_RST : (k == 5) ? GAIN_RST : '0;
                    active_q[s][k] <= (k == 0) ? B0_RST : (k == 5) ? GAIN_RST : '0;
                end
            end
`ifdef SOS_CTRL_BYPASS_EN
            byp_shadow_q <= '0;
            byp_active_q <= '0;
`endif
        end else begin
            stage_trig_q   <= '0;
            sample_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (sample_trig_i) begin
                        if (first_hit_c) begin
                            state_q      <= S_FIRE;
                            idx_q        <= first_idx_c;
                            tmo_cnt_q    <= '0;
                            stage_trig_q <= STAGES'(1) << first_idx_c;
                            busy_q       <= 1'b1;
                        end else begin
                            sample_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (cur_done_c) begin
                        if (next_hit_c) begin
                            state_q      <= S_FIRE;
                            idx_q        <= next_idx_c;
                            tmo_cnt_q    <= '0;
                            stage_trig_q <= STAGES'(1) << next_idx_c;
                        end else begin
                            state_q        <= S_IDLE;
                            busy_q         <= 1'b0;
                            sample_valid_q <= 1'b1;
                        end
                    end else if (tmo_hit_c) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q   <= S_WAIT;
                        tmo_cnt_q <= tmo_cnt_q + TCW'(1);
                    end
                end
            endcase

            if (cfg_we_i) begin
                for (int s = 0; s < STAGES; s++) begin
                    for (int k = 0; k < NC; k++) begin
                        if (int'(cfg_stage_i) == s && int'(cfg_sel_i) == k) begin
                            shadow_q[s][k] <= cfg_data_i;
                        end
                    end
`ifdef SOS_CTRL_BYPASS_EN
                    if (int'(cfg_stage_i) == s && int'(cfg_sel_i) == 6) begin
                        byp_shadow_q[s] <= cfg_data_i[0];
                    end
`endif
                end
            end

            if (copy_c) begin
                for (int s = 0; s < STAGES; s++) begin
                    for (int k = 0; k < NC; k++) begin
                        active_q[s][k] <= shadow_q[s][k];
                    end
                end
`ifdef SOS_CTRL_BYPASS_EN
                byp_active_q <= byp_shadow_q;
`endif
            end

            commit_pend_q <= ret_idle_c ? 1'b0 : (commit_pend_q | (chain_busy_c & cfg_commit_i));
            overrun_q     <= (overrun_q & ~cfg_clr_i) | (sample_trig_i & chain_busy_c);
            timeout_err_q <= (timeout_err_q & ~cfg_clr_i) | tmo_hit_c;
        end
    end

    // Flatten active coefficients onto the per-stage packed buses
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            coef_b0_o[s*CW +: CW]   = active_q[s][0];
            coef_b1_o[s*CW +: CW]   = active_q[s][1];
            coef_b2_o[s*CW +: CW]   = active_q[s][2];
            coef_a1_o[s*CW +: CW]   = active_q[s][3];
            coef_a2_o[s*CW +: CW]   = active_q[s][4];
            coef_gain_o[s*CW +: CW] = active_q[s][5];
        end
    end

`ifdef SOS_CTRL_BYPASS_EN
    assign stage_bypass_o = byp_active_q;
`endif
    assign stage_trig_o   = stage_trig_q;
    assign busy_o         = busy_q;
    assign sample_valid_o = sample_valid_q;
    assign commit_pend_o  = commit_pend_q;
    assign overrun_o      = overrun_q;
    assign timeout_err_o  = timeout_err_q;

endmodule
